// File: rtl/dmem_access_ctrl.sv
// Load/store controller in front of a word-wide data RAM with async read and sync write.
// Sub-word stores are done as read-modify-write; every request gets one response pulse.
module dmem_access_ctrl #(
    parameter int unsigned ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_d,
    output logic              ram_we,
    input  logic [31:0]       ram_q
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] MERGE  = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [1:0]        lane_q, lane_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]       ram_d_q, ram_d_d;
    logic              ram_we_q, ram_we_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [31:0] off;
    logic        req_err;
    logic [31:0] lane_data;
    logic [31:0] load_val;
    logic [31:0] merged;

    // Addresses below BASE_ADDR wrap to huge offsets and fail the range check.
    assign off     = req_addr - BASE_ADDR;
    assign req_err = (req_size == 2'b11)
                   || ((req_size == SZ_H) && off[0])
                   || ((req_size == SZ_W) && (off[1:0] != 2'b00))
                   || ((off >> (ADDR_W + 2)) != 32'd0);

    assign lane_data = ram_q >> {lane_q, 3'b000};

    always_comb begin
        load_val = ram_q;
        case (size_q)
            SZ_B: load_val = uns_q ? {24'd0, lane_data[7:0]}
                                   : {{24{lane_data[7]}}, lane_data[7:0]};
            SZ_H: load_val = uns_q ? {16'd0, lane_data[15:0]}
                                   : {{16{lane_data[15]}}, lane_data[15:0]};
            default: load_val = ram_q;
        endcase
    end

    always_comb begin
        merged = ram_q;
        if (size_q == SZ_B) begin
            case (lane_q)
                2'd0: merged[7:0]   = wdata_q[7:0];
                2'd1: merged[15:8]  = wdata_q[7:0];
                2'd2: merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (lane_q[1]) begin
            merged[31:16] = wdata_q[15:0];
        end else begin
            merged[15:0] = wdata_q[15:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        size_d     = size_q;
        uns_d      = uns_q;
        lane_d     = lane_q;
        wdata_d    = wdata_q;
        ram_addr_d = ram_addr_q;
        ram_d_d    = ram_d_q;
        ram_we_d   = 1'b0;
        rdata_d    = rdata_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    lane_d  = off[1:0];
                    wdata_d = req_wdata;
                    if (req_err) begin
                        rdata_d = 32'd0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        ram_addr_d = off[ADDR_W+1:2];
                        state_d    = ACCESS;
                        if (req_we && (req_size == SZ_W)) begin
                            ram_we_d = 1'b1;
                            ram_d_d  = req_wdata;
                        end
                    end
                end
            end
            ACCESS: begin
                if (!we_q) begin
                    rdata_d = load_val;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (size_q == SZ_W) begin
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else begin
                    ram_d_d  = merged;
                    ram_we_d = 1'b1;
                    state_d  = MERGE;
                end
            end
            MERGE: begin
                rdata_d = 32'd0;
                err_d   = 1'b0;
                state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            size_q     <= 2'd0;
            uns_q      <= 1'b0;
            lane_q     <= 2'd0;
            wdata_q    <= 32'd0;
            ram_addr_q <= '0;
            ram_d_q    <= 32'd0;
            ram_we_q   <= 1'b0;
            rdata_q    <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            lane_q     <= lane_d;
            wdata_q    <= wdata_d;
            ram_addr_q <= ram_addr_d;
            ram_d_q    <= ram_d_d;
            ram_we_q   <= ram_we_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign ram_addr   = ram_addr_q;
    assign ram_d      = ram_d_q;
    assign ram_we     = ram_we_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: a driver queues expected responses, a monitor
// pops and compares them; a behavioural RAM sits on the RAM port.
module tb_dmem_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [9:0]  ram_addr;
    logic [31:0] ram_d;
    logic        ram_we;
    logic [31:0] ram_q;

    dmem_access_ctrl #(
        .ADDR_W   (10),
        .BASE_ADDR(32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .ram_addr    (ram_addr),
        .ram_d       (ram_d),
        .ram_we      (ram_we),
        .ram_q       (ram_q)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mem [0:1023];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          wr_cnt = 0;
    int          acc_cnt = 0;
    int          n_issued = 0;
    logic [9:0]  last_wr_addr = '0;

    assign ram_q = mem[ram_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM model plus write and accept counters, all sampled on the active edge
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst_n && req_valid && req_ready) acc_cnt++;
            if (ram_we) begin
                wr_cnt++;
                last_wr_addr = ram_addr;
                mem[ram_addr] = ram_d;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && resp_valid) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_resp: got rdata %h err %b expected none",
                             resp_rdata, resp_err);
                end else begin
                    e = sb_q.pop_front();
                    chk({e.name, "_rdata"}, resp_rdata, e.rdata);
                    chk({e.name, "_err"}, {31'd0, resp_err}, {31'd0, e.err});
                    chk({e.name, "_cycle"}, cyc, e.cyc);
                end
            end
        end
    end

    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] er, input logic ee, input int lat,
                         input string nm);
        exp_t e;
        int   g;
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        g = 0;
        while (!req_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (!req_ready) begin
            chk({nm, "_accept_timeout"}, 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        e.rdata = er;
        e.err   = ee;
        e.cyc   = cyc + lat;
        e.name  = nm;
        sb_q.push_back(e);
        n_issued++;
        @(posedge clk);
    endtask

    task automatic drain();
        int g;
        @(negedge clk);
        req_valid = 1'b0;
        g = 0;
        while (sb_q.size() != 0 && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (sb_q.size() != 0) chk("drain_timeout", sb_q.size(), 0);
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_ready"}, {31'd0, req_ready}, 32'd1);
        chk({nm, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
        chk({nm, "_resp_rdata"}, resp_rdata, 32'd0);
        chk({nm, "_resp_err"}, {31'd0, resp_err}, 32'd0);
        chk({nm, "_ram_we"}, {31'd0, ram_we}, 32'd0);
        chk({nm, "_ram_addr"}, {22'd0, ram_addr}, 32'd0);
        chk({nm, "_ram_d"}, ram_d, 32'd0);
    endtask

    initial begin
        int w0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;
        rst_n        = 1'b1;
        #1 rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // 1: sw then lw
        w0 = wr_cnt;
        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, "sw_10");
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, "lw_10");
        drain();
        chk("t1_writes", wr_cnt - w0, 1);
        chk("t1_wr_addr", {22'd0, last_wr_addr}, 32'd4);

        // 2: sb then byte loads
        w0 = wr_cnt;
        issue(1'b1, 2'd0, 1'b0, 32'h13, 32'h12, 32'h0, 1'b0, 3, "sb_13");
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h12ADBEEF, 1'b0, 2, "lw_10b");
        issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'h00000012, 1'b0, 2, "lb_13");
        issue(1'b0, 2'd0, 1'b0, 32'h12, 32'h0, 32'hFFFFFFAD, 1'b0, 2, "lb_12");
        issue(1'b0, 2'd0, 1'b1, 32'h12, 32'h0, 32'h000000AD, 1'b0, 2, "lbu_12");
        drain();
        chk("t2_writes", wr_cnt - w0, 1);

        // 3: sh on upper half then half loads
        w0 = wr_cnt;
        issue(1'b1, 2'd1, 1'b0, 32'h16, 32'h8001, 32'h0, 1'b0, 3, "sh_16");
        issue(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 32'h80010000, 1'b0, 2, "lw_14");
        issue(1'b0, 2'd1, 1'b0, 32'h16, 32'h0, 32'hFFFF8001, 1'b0, 2, "lh_16");
        issue(1'b0, 2'd1, 1'b1, 32'h16, 32'h0, 32'h00008001, 1'b0, 2, "lhu_16");
        drain();
        chk("t3_writes", wr_cnt - w0, 1);

        // 4: errors, plus the last legal word
        w0 = wr_cnt;
        issue(1'b0, 2'd2, 1'b0, 32'h2, 32'h0, 32'h0, 1'b1, 1, "err_lw_2");
        issue(1'b1, 2'd1, 1'b0, 32'h1, 32'hFFFF, 32'h0, 1'b1, 1, "err_sh_1");
        issue(1'b1, 2'd3, 1'b0, 32'h0, 32'hFFFF, 32'h0, 1'b1, 1, "err_size3");
        issue(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 32'h0, 1'b1, 1, "err_lw_1000");
        issue(1'b1, 2'd2, 1'b0, 32'h1000, 32'h1, 32'h0, 1'b1, 1, "err_sw_1000");
        issue(1'b0, 2'd2, 1'b0, 32'hFFC, 32'h0, 32'h0, 1'b0, 2, "lw_ffc");
        drain();
        chk("t4_writes", wr_cnt - w0, 0);

        // 5: valid held high across back-to-back requests
        w0 = wr_cnt;
        issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, 32'h0, 1'b0, 2, "b2b_sw");
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h11223344, 1'b0, 2, "b2b_lw");
        issue(1'b1, 2'd0, 1'b0, 32'h21, 32'hA5, 32'h0, 1'b0, 3, "b2b_sb");
        issue(1'b0, 2'd0, 1'b1, 32'h21, 32'h0, 32'h000000A5, 1'b0, 2, "b2b_lbu");
        issue(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 32'h00001122, 1'b0, 2, "b2b_lh");
        drain();
        chk("t5_writes", wr_cnt - w0, 2);
        chk("t5_accepts", acc_cnt, n_issued);

        // 6: reset during MERGE of an sb
        issue(1'b1, 2'd2, 1'b0, 32'h24, 32'hCAFEF00D, 32'h0, 1'b0, 2, "sw_24");
        drain();
        w0 = wr_cnt;
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = 1'b1;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = 32'h25;
        req_wdata    = 32'h55;
        chk("t6_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("t6_merge_we", {31'd0, ram_we}, 32'd1);
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("t6_mid_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("t6_writes", wr_cnt - w0, 0);
        chk("t6_mem9", mem[9], 32'hCAFEF00D);
        issue(1'b0, 2'd2, 1'b0, 32'h24, 32'h0, 32'hCAFEF00D, 1'b0, 2, "lw_24_after_rst");
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
